pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 6, number of stall-controlled stages (bit 0 = PC, ascending toward WB).
REQ-002 SHALL have parameter ADDR_W, default 32, width of exception redirect address.
REQ-003 SHALL have parameter WDT_LIMIT, default 1023, consecutive-stall cycles before watchdog trips; counter width $clog2(WDT_LIMIT+1).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port stallreq_i  in  NUM_STAGES  per-stage stall request.
REQ-007 SHALL have port bus_busy_i  in  1  memory-stage bus transaction outstanding.
REQ-008 SHALL have port except_valid_i  in  1  committed exception or eret from memory stage.
REQ-009 SHALL have port except_pc_i  in  ADDR_W  redirect target, valid with except_valid_i.
REQ-010 SHALL have port stall_o  out  NUM_STAGES  per-stage hold.
REQ-011 SHALL have port flush_o  out  1  pipeline flush pulse.
REQ-012 SHALL have port new_pc_o  out  ADDR_W  PC redirect, valid while flush_o=1.
REQ-013 SHALL have port wdt_timeout_o  out  1  sticky watchdog flag.

Function
REQ-014 SHALL implement FSM states RUN, DRAIN, FLUSH.
REQ-015 RUN: stall_o combinational thermometer; k = highest set bit of stallreq_i; stall_o[i]=1 for all i<=k, 0 above; all-zero if no request.
REQ-016 RUN, except_valid_i=1, bus_busy_i=0: latch except_pc_i, next state FLUSH.
REQ-017 RUN, except_valid_i=1, bus_busy_i=1: latch except_pc_i, next state DRAIN.
REQ-018 DRAIN: stall_o all-ones; leave to FLUSH in the cycle after bus_busy_i samples 0.
REQ-019 FLUSH: flush_o=1, new_pc_o=latched address, stall_o all-zero, stallreq_i ignored; next state RUN unconditionally.
REQ-020 flush_o SHALL be exactly one cycle wide; latency except_valid_i -> flush_o is 1 cycle when bus idle.
REQ-021 except_valid_i during DRAIN or FLUSH SHALL be ignored; first exception wins, latched address not overwritten.
REQ-022 new_pc_o SHALL hold last latched address outside FLUSH.
REQ-023 NUM_STAGES=1 SHALL be legal: stall_o = stallreq_i[0] in RUN.

Reset
REQ-024 rst=1 SHALL force state RUN, latched address 0, flush_o 0, new_pc_o 0, watchdog count 0, wdt_timeout_o 0.
REQ-025 rst during DRAIN or FLUSH SHALL abandon the pending redirect; no flush_o pulse after reset release.
REQ-026 stall_o during rst SHALL be all-zero.

Configuration
REQ-027 Macro PIPE_CTRL_WATCHDOG_EN defined: counter increments each cycle stall_o[0]=1, clears when stall_o[0]=0, saturates at WDT_LIMIT; reaching WDT_LIMIT sets wdt_timeout_o, sticky until rst.
REQ-028 Macro undefined: no counter instantiated, wdt_timeout_o tied 0, all other behaviour identical.

Structure
REQ-029 Package pipe_pkg SHALL hold the FSM state enum and default ADDR_W constant, shared with pipeline stage registers.
REQ-030 Sub-module pipe_stall_enc SHALL implement the combinational thermometer encoder of REQ-015, parametrised by NUM_STAGES.

Verification
REQ-031 stallreq_i=6'b001000 in RUN -> stall_o=6'b001111 same cycle; stallreq_i=0 -> stall_o=0.
REQ-032 except_valid_i=1, except_pc_i=32'hBFC00380, bus_busy_i=0 -> next cycle flush_o=1, new_pc_o=32'hBFC00380, stall_o=0; following cycle flush_o=0.
REQ-033 except_valid_i=1 with bus_busy_i=1 held 3 cycles -> stall_o=6'b111111 for 3 cycles, flush_o one cycle after bus_busy_i falls.
REQ-034 second except_valid_i (pc 32'h80000180) during DRAIN -> flush uses first address only.
REQ-035 rst asserted during DRAIN -> no flush_o after release, new_pc_o=0.
REQ-036 With PIPE_CTRL_WATCHDOG_EN, WDT_LIMIT=15, stallreq_i[0]=1 for 15 cycles -> wdt_timeout_o=1 and stays 1 after request drops; 14 cycles -> stays 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: pipeline control FSM state type and default redirect width
package pipe_pkg;
   typedef enum logic [1:0] {RUN, DRAIN, FLUSH} pipe_state_e;
   localparam int ADDR_W_DEF = 32;
endpackage

// File: rtl/pipe_stall_enc.sv
// pipe_stall_enc: thermometer encoder, every stage at or below the highest request holds
module pipe_stall_enc #(
   parameter int NUM_STAGES = 6
) (
   input  logic [NUM_STAGES-1:0] req_i,
   output logic [NUM_STAGES-1:0] therm_o
);
   logic acc;
   always_comb begin
      therm_o = '0;
      acc = 1'b0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         acc = acc | req_i[i];
         therm_o[i] = acc;
      end
   end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller with exception redirect.
// Optional stall watchdog enabled by defining PIPE_CTRL_WATCHDOG_EN.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int NUM_STAGES = 6,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int WDT_LIMIT  = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_STAGES-1:0] stallreq_i,
   input  logic                  bus_busy_i,
   input  logic                  except_valid_i,
   input  logic [ADDR_W-1:0]     except_pc_i,
   output logic [NUM_STAGES-1:0] stall_o,
   output logic                  flush_o,
   output logic [ADDR_W-1:0]     new_pc_o,
   output logic                  wdt_timeout_o
);
   pipe_state_e           state_q, state_d;
   logic [ADDR_W-1:0]     pc_q, pc_d;
   logic [NUM_STAGES-1:0] therm;

   pipe_stall_enc #(.NUM_STAGES(NUM_STAGES)) u_enc (.req_i(stallreq_i), .therm_o(therm));

   // Only RUN accepts an exception, so the first one's target is kept through DRAIN/FLUSH
   always_comb begin
      pc_d    = (state_q == RUN && except_valid_i) ? except_pc_i : pc_q;
      state_d = (state_q == FLUSH) ? RUN
              : (state_q == DRAIN || except_valid_i) ? (bus_busy_i ? DRAIN : FLUSH)
              : RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign stall_o  = rst ? '0 : (state_q == DRAIN) ? '1 : (state_q == FLUSH) ? '0 : therm;
   assign flush_o  = !rst && state_q == FLUSH;
   assign new_pc_o = rst ? '0 : pc_q;

`ifdef PIPE_CTRL_WATCHDOG_EN
   localparam int CW = $clog2(WDT_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(WDT_LIMIT);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wdt_q;
   assign cnt_d = !stall_o[0] ? '0 : (cnt_q == LIM) ? cnt_q : cnt_q + 1'b1;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         wdt_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         wdt_q <= wdt_q | (cnt_d == LIM);
      end
   end
   assign wdt_timeout_o = wdt_q;
`else
   assign wdt_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of stall encoding, exception flush/drain, reset and watchdog
module tb_pipe_ctrl;
`ifdef PIPE_CTRL_WATCHDOG_EN
   localparam logic WD = 1'b1;
`else
   localparam logic WD = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst, bus_busy, ev, flush, wdt;
   logic [5:0]  stallreq, stall;
   logic [31:0] epc, new_pc;
   int          n_cmp = 0, n_err = 0;

   pipe_ctrl #(.NUM_STAGES(6), .ADDR_W(32), .WDT_LIMIT(15)) dut (
      .clk(clk), .rst(rst), .stallreq_i(stallreq), .bus_busy_i(bus_busy),
      .except_valid_i(ev), .except_pc_i(epc), .stall_o(stall), .flush_o(flush),
      .new_pc_o(new_pc), .wdt_timeout_o(wdt)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; bus_busy = 1'b0; ev = 1'b0; epc = '0; stallreq = 6'b001000;
      tick(2);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_newpc", new_pc, 32'h0);
      chk("rst_wdt", 32'(wdt), 32'h0);
      rst = 1'b0; #1;
      chk("therm_001000", 32'(stall), 32'h0F);
      stallreq = 6'b000000; #1;
      chk("therm_zero", 32'(stall), 32'h00);
      stallreq = 6'b100000; #1;
      chk("therm_100000", 32'(stall), 32'h3F);
      stallreq = 6'b000001; #1;
      chk("therm_000001", 32'(stall), 32'h01);
      stallreq = 6'b010010; #1;
      chk("therm_010010", 32'(stall), 32'h1F);
      stallreq = 6'b000000;
      // idle-bus exception: flush next cycle
      ev = 1'b1; epc = 32'hBFC00380;
      tick();
      ev = 1'b0; stallreq = 6'b111111; #1;
      chk("fl_flush", 32'(flush), 32'h1);
      chk("fl_newpc", new_pc, 32'hBFC00380);
      chk("fl_stall_ignored", 32'(stall), 32'h0);
      tick();
      chk("fl_one_cycle", 32'(flush), 32'h0);
      chk("fl_newpc_hold", new_pc, 32'hBFC00380);
      chk("fl_run_stall", 32'(stall), 32'h3F);
      stallreq = 6'b000000;
      // busy bus: drain 3 cycles, second exception ignored
      ev = 1'b1; epc = 32'h80001000; bus_busy = 1'b1;
      tick();
      epc = 32'h80000180; #1;
      chk("dr1_stall", 32'(stall), 32'h3F);
      chk("dr1_flush", 32'(flush), 32'h0);
      tick();
      ev = 1'b0; #1;
      chk("dr2_stall", 32'(stall), 32'h3F);
      tick();
      bus_busy = 1'b0; #1;
      chk("dr3_stall", 32'(stall), 32'h3F);
      chk("dr3_flush", 32'(flush), 32'h0);
      tick();
      chk("dr_flush", 32'(flush), 32'h1);
      chk("dr_first_pc", new_pc, 32'h80001000);
      chk("dr_flush_stall", 32'(stall), 32'h0);
      tick();
      chk("dr_flush_end", 32'(flush), 32'h0);
      // exception during FLUSH ignored
      ev = 1'b1; epc = 32'h11110000;
      tick();
      epc = 32'h22220000;
      tick();
      ev = 1'b0; #1;
      chk("fi_flush", 32'(flush), 32'h0);
      chk("fi_newpc", new_pc, 32'h11110000);
      // reset during DRAIN abandons redirect
      ev = 1'b1; epc = 32'hDEAD0000; bus_busy = 1'b1;
      tick();
      ev = 1'b0; rst = 1'b1; #1;
      chk("rd_stall_in_rst", 32'(stall), 32'h0);
      tick();
      rst = 1'b0; bus_busy = 1'b0; #1;
      chk("rd_flush0", 32'(flush), 32'h0);
      chk("rd_newpc", new_pc, 32'h0);
      chk("rd_stall", 32'(stall), 32'h0);
      tick();
      chk("rd_flush1", 32'(flush), 32'h0);
      tick();
      chk("rd_flush2", 32'(flush), 32'h0);
      // watchdog: 14 stall cycles stay clear, 15 trip and stick
      stallreq = 6'b000001;
      tick(14);
      stallreq = 6'b000000; #1;
      chk("wdt_14", 32'(wdt), 32'h0);
      tick();
      stallreq = 6'b000001;
      tick(15);
      stallreq = 6'b000000; #1;
      chk("wdt_15", 32'(wdt), 32'(WD));
      tick(2);
      chk("wdt_sticky", 32'(wdt), 32'(WD));
      rst = 1'b1;
      tick();
      chk("wdt_rst", 32'(wdt), 32'h0);
      rst = 1'b0;
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
